// File: rtl/audio_out_pkg.sv
// Shared types and the reference round-and-saturate function for the DAC output path.
package audio_out_pkg;

  localparam int FXP_SIZE = 16;

  typedef logic signed [FXP_SIZE-1:0]   sample_t;
  typedef logic signed [2*FXP_SIZE-1:0] wide_sample_t;

  // Word-select levels: left slot while low, right slot while high.
  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  localparam sample_t SAMPLE_MAX = {1'b0, {(FXP_SIZE-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(FXP_SIZE-1){1'b0}}};

  // Sign-extended limits at the one-bit-wider intermediate width.
  localparam logic signed [2*FXP_SIZE:0] WIDE_MAX = (2*FXP_SIZE+1)'(SAMPLE_MAX);
  localparam logic signed [2*FXP_SIZE:0] WIDE_MIN = (2*FXP_SIZE+1)'(SAMPLE_MIN);

  // Round half up by sh bits, then clamp to the signed sample range.
  function automatic sample_t requant_sat(input wide_sample_t wide, input int sh);
    logic signed [2*FXP_SIZE:0] acc;
    acc = {wide[2*FXP_SIZE-1], wide};
    if (sh > 0) acc = acc + ((2*FXP_SIZE+1)'(1) << (sh - 1));
    acc = acc >>> sh;
    if (acc > WIDE_MAX) return SAMPLE_MAX;
    if (acc < WIDE_MIN) return SAMPLE_MIN;
    return acc[FXP_SIZE-1:0];
  endfunction

endpackage

// File: rtl/i2s_tx_out_fxp_requant.sv
// Combinational re-quantiser: wide fixed-point in, rounded and saturated DAC word out.
module fxp_requant #(
  parameter int fxp_size = 16,
  parameter int in_frac  = 16,
  parameter int out_frac = 12
) (
  input  logic [2*fxp_size-1:0] wide,
  output logic [fxp_size-1:0]   word
);

  localparam int W  = 2*fxp_size + 1;
  localparam int SH = in_frac - out_frac;

  // Half an output LSB, added ahead of the shift; nothing to add when no bits are dropped.
  localparam logic signed [W-1:0] RND     = (SH > 0) ? (W'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;
  localparam logic signed [W-1:0] SAT_MAX = W'((64'd1 << (fxp_size - 1)) - 64'd1);
  localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [W-1:0] ext;
  logic signed [W-1:0] rounded;
  logic signed [W-1:0] shifted;

  // Extend by one bit so the rounding add cannot wrap, shift, then clamp.
  always_comb begin
    ext     = {wide[2*fxp_size-1], wide};
    rounded = ext + RND;
    shifted = rounded >>> SH;
    if (shifted > SAT_MAX)      word = {1'b0, {(fxp_size-1){1'b1}}};
    else if (shifted < SAT_MIN) word = {1'b1, {(fxp_size-1){1'b0}}};
    else                        word = shifted[fxp_size-1:0];
  end

endmodule

// File: rtl/i2s_tx_out.sv
// I2S transmitter: one-entry sample buffer, bclk/lrclk generation and MSB-first
// serialisation of the mono output word into both slots of every frame.
module i2s_tx_out
  import audio_out_pkg::*;
#(
  parameter int fxp_size = 16,
  parameter int in_frac  = 16,
  parameter int out_frac = 12,
  parameter int clk_div  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*fxp_size-1:0] i_sample,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_bclk,
  output logic                  o_lrclk,
  output logic                  o_sdata,
  output logic                  o_underrun
);

  localparam int FW = 2*fxp_size;
  localparam int DW = $clog2(clk_div);
  localparam int BW = $clog2(FW);

  logic [DW-1:0]       div_cnt_reg;
  logic                bclk_reg;
  logic                lrclk_reg;
  logic                sdata_reg;
  logic                underrun_reg;
  logic [BW-1:0]       bit_cnt_reg;
  logic [FW-1:0]       frame_reg;
  logic [fxp_size-1:0] buf_reg;
  logic                buf_full_reg;

  logic [fxp_size-1:0] word;
  logic                div_tc;
  logic                fall;
  logic [BW-1:0]       bit_next;
  logic                load;
  logic [FW-1:0]       frame_next;
  logic                accept;

  fxp_requant #(
    .fxp_size (fxp_size),
    .in_frac  (in_frac),
    .out_frac (out_frac)
  ) u_requant (
    .wide (i_sample),
    .word (word)
  );

  // Decode divider terminal count, the falling bclk edge and the frame-load slot (k = 1).
  always_comb begin
    div_tc     = (div_cnt_reg == DW'(clk_div - 1));
    fall       = div_tc && bclk_reg;
    bit_next   = (bit_cnt_reg == BW'(FW - 1)) ? '0 : bit_cnt_reg + 1'b1;
    load       = fall && (bit_next == BW'(1));
    frame_next = (load && buf_full_reg) ? {buf_reg, buf_reg} : frame_reg;
    // A buffer being drained this cycle cannot also be refilled.
    accept     = i_valid && !buf_full_reg;
  end

  // Bit clock divider and serialiser; sdata lags lrclk by one bit, and bit_cnt_reg
  // already holds (k-1) mod 2*fxp_size, which is the frame bit to send at edge k.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg  <= '0;
      bclk_reg     <= 1'b0;
      lrclk_reg    <= LR_RIGHT;
      sdata_reg    <= 1'b0;
      underrun_reg <= 1'b0;
      bit_cnt_reg  <= BW'(FW - 1);
      frame_reg    <= '0;
    end else begin
      underrun_reg <= 1'b0;
      if (div_tc) begin
        div_cnt_reg <= '0;
        bclk_reg    <= ~bclk_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end
      if (fall) begin
        bit_cnt_reg <= bit_next;
        lrclk_reg   <= (bit_next >= BW'(fxp_size)) ? LR_RIGHT : LR_LEFT;
        sdata_reg   <= frame_next[BW'(FW - 1) - bit_cnt_reg];
        frame_reg   <= frame_next;
        if (load && !buf_full_reg) underrun_reg <= 1'b1;
      end
    end
  end

  // One-entry input buffer: filled by a handshake, drained at the frame-load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_reg <= 1'b0;
      buf_reg      <= '0;
    end else if (load && buf_full_reg) begin
      buf_full_reg <= 1'b0;
    end else if (accept) begin
      buf_full_reg <= 1'b1;
      buf_reg      <= word;
    end
  end

  assign o_ready    = ~buf_full_reg;
  assign o_bclk     = bclk_reg;
  assign o_lrclk    = lrclk_reg;
  assign o_sdata    = sdata_reg;
  assign o_underrun = underrun_reg;

endmodule

// File: tb/tb_i2s_tx_out.sv
// Directed bench for i2s_tx_out at default parameters (16-bit words, clk_div = 4).
module tb_i2s_tx_out;
  import audio_out_pkg::*;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_sample = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        o_bclk;
  logic        o_lrclk;
  logic        o_sdata;
  logic        o_underrun;

  int checks = 0;
  int errors = 0;
  int ur_total = 0;
  int acc_total = 0;

  logic [31:0] vin  [6] = '{32'h0000_0018, 32'h0000_0017, 32'hFFFF_FFE8,
                            32'h0010_0000, 32'hFFF0_0000, 32'h7FFF_FFFF};
  logic [15:0] vexp [6] = '{16'h0002, 16'h0001, 16'hFFFF,
                            16'h7FFF, 16'h8000, 16'h7FFF};

  always #5 clk = ~clk;

  i2s_tx_out dut (
    .clk        (clk),
    .rst        (rst),
    .i_sample   (i_sample),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_bclk     (o_bclk),
    .o_lrclk    (o_lrclk),
    .o_sdata    (o_sdata),
    .o_underrun (o_underrun)
  );

  // Count underrun pulses and accepted handshakes as the DUT sees them.
  always @(posedge clk) begin
    if (o_underrun) ur_total <= ur_total + 1;
    if (!rst && i_valid && o_ready) acc_total <= acc_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  // Wait for the next falling bclk edge; n = clk cycles waited.
  task automatic wait_fall(output logic lr, output logic sd, output logic rdy_before, output int n);
    logic prev_b;
    logic prev_r;
    n = 0; lr = 1'b0; sd = 1'b0; rdy_before = 1'b0;
    prev_b = o_bclk;
    for (int i = 0; i < 4*CLK_DIV; i++) begin
      prev_r = o_ready;
      @(negedge clk);
      n++;
      if (prev_b && !o_bclk) begin
        lr = o_lrclk; sd = o_sdata; rdy_before = prev_r;
        return;
      end
      prev_b = o_bclk;
    end
    chk("fall_timeout", 32'(n), 32'd0);
  endtask

  // Called just after a k=0 edge; collects edges k=1..31 and the next k=0.
  task automatic cap_from_k1(output logic [31:0] bits, output logic [31:0] lrb,
                             output logic rdy_load, output int urd, output int accd);
    int u0, a0, n;
    logic lr, sd, rb;
    u0 = ur_total; a0 = acc_total; bits = '0; lrb = '0; rdy_load = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_fall(lr, sd, rb, n);
      bits = {bits[30:0], sd};
      lrb  = {lrb[30:0], lr};
      if (i == 0) rdy_load = rb;
    end
    urd = ur_total - u0; accd = acc_total - a0;
  endtask

  task automatic send(input logic [31:0] s);
    i_sample = s; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] bits, lrb;
    logic rl, lr, sd, rb;
    int urd, accd, n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_bclk", 32'(o_bclk), 32'd0);
    chk("rst_lrclk", 32'(o_lrclk), 32'd1);
    chk("rst_sdata", 32'(o_sdata), 32'd0);
    chk("rst_underrun", 32'(o_underrun), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);

    // Basic frame: accept right at release, first fall after 2*clk_div cycles
    rst = 1'b0; i_sample = 32'h0001_2340; i_valid = 1'b1;
    @(negedge clk);
    chk("ready_after_accept", 32'(o_ready), 32'd0);
    i_valid = 1'b0;
    wait_fall(lr, sd, rb, n);
    chk("first_fall_cycles", 32'(n + 1), 32'(2*CLK_DIV));
    chk("k0_lrclk", 32'(lr), 32'd0);
    chk("k0_sdata", 32'(sd), 32'd0);
    cap_from_k1(bits, lrb, rl, urd, accd);
    chk("basic_frame", bits, 32'h1234_1234);
    chk("basic_lrclk", lrb, 32'h0001_FFFE);
    chk("basic_underrun", 32'(urd), 32'd0);

    // Rounding and saturation vectors
    for (int i = 0; i < 6; i++) begin
      chk("pkg_fn", {16'h0, requant_sat(vin[i], 4)}, {16'h0, vexp[i]});
      send(vin[i]);
      cap_from_k1(bits, lrb, rl, urd, accd);
      chk("vec_frame", bits, {vexp[i], vexp[i]});
      chk("vec_underrun", 32'(urd), 32'd0);
    end

    // Underrun: no sample for one frame repeats the last word, one pulse
    cap_from_k1(bits, lrb, rl, urd, accd);
    chk("ur_frame", bits, 32'h7FFF_7FFF);
    chk("ur_pulses", 32'(urd), 32'd1);
    send(32'h0001_2340);
    cap_from_k1(bits, lrb, rl, urd, accd);
    chk("ur_recover", bits, 32'h1234_1234);
    chk("ur_recover_pulses", 32'(urd), 32'd0);

    // Backpressure: valid held high
    i_sample = 32'hFFFE_DCC0; i_valid = 1'b1;
    cap_from_k1(bits, lrb, rl, urd, accd);
    chk("bp_frame1", bits, 32'hEDCC_EDCC);
    chk("bp_ready_at_load1", 32'(rl), 32'd0);
    cap_from_k1(bits, lrb, rl, urd, accd);
    chk("bp_frame2", bits, 32'hEDCC_EDCC);
    chk("bp_ready_at_load2", 32'(rl), 32'd0);
    chk("bp_accepts", 32'(accd), 32'd1);
    chk("bp_underrun", 32'(urd), 32'd0);
    i_valid = 1'b0;

    // Mid-frame reset at k=10 with a pending buffer entry
    wait_fall(lr, sd, rb, n);
    send(32'h0001_2340);
    for (int i = 0; i < 9; i++) wait_fall(lr, sd, rb, n);
    chk("pre_rst_ready", 32'(o_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_bclk", 32'(o_bclk), 32'd0);
    chk("mrst_lrclk", 32'(o_lrclk), 32'd1);
    chk("mrst_sdata", 32'(o_sdata), 32'd0);
    chk("mrst_underrun", 32'(o_underrun), 32'd0);
    chk("mrst_ready", 32'(o_ready), 32'd1);
    rst = 1'b0;
    wait_fall(lr, sd, rb, n);
    chk("mrst_first_fall", 32'(n), 32'(2*CLK_DIV));
    chk("mrst_k0_lrclk", 32'(lr), 32'd0);
    cap_from_k1(bits, lrb, rl, urd, accd);
    chk("mrst_frame", bits, 32'h0000_0000);
    chk("mrst_underrun", 32'(urd), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
